// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall, flush and HALT parking for the front end.
// Define IFID_STATS_EN to add the saturating stall_count output.
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_inst,
  input  logic [15:0] fetch_pc_inc,
  input  logic        fetch_valid,
  input  logic        stall_req,
  input  logic [1:0]  stall_cycles,
  input  logic        flush,
  output logic [15:0] dec_inst,
  output logic [15:0] dec_pc_inc,
  output logic        dec_valid,
  output logic        pc_hold,
  output logic        bubble,
  output logic        halted
`ifdef IFID_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [1:0]  RUN    = 2'd0;
  localparam logic [1:0]  STALL  = 2'd1;
  localparam logic [1:0]  HALTED = 2'd2;
  localparam logic [15:0] NOP    = 16'h0800;
  localparam logic [15:0] HALT   = 16'h0000;

  logic [1:0]  state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] inst_nxt, pc_nxt;
  logic        valid_nxt;
  logic        hold_c, bub_c;
  logic        halt_seen;

  assign halt_seen = dec_valid && (dec_inst == HALT);

  // Priority chain: flush, parked, stalling, new request, HALT in decode, advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inst_nxt  = dec_inst;
    pc_nxt    = dec_pc_inc;
    valid_nxt = dec_valid;
    hold_c    = 1'b0;
    bub_c     = 1'b0;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
      inst_nxt  = NOP;
      valid_nxt = 1'b0;
      bub_c     = 1'b1;
    end else if (state == HALTED) begin
      hold_c = 1'b1;
      bub_c  = 1'b1;
    end else if (state == STALL) begin
      hold_c  = 1'b1;
      bub_c   = 1'b1;
      cnt_nxt = cnt - 2'd1;
      if (cnt == 2'd1) state_nxt = RUN;
    end else if (stall_req) begin
      // The request cycle is stall cycle 1; a length of 0 or 1 needs no STALL state.
      hold_c = 1'b1;
      bub_c  = 1'b1;
      if (stall_cycles > 2'd1) begin
        cnt_nxt   = stall_cycles - 2'd1;
        state_nxt = STALL;
      end
    end else if (halt_seen) begin
      // HALT flows on to ID/EX this cycle; IF/ID keeps it while parked.
      hold_c    = 1'b1;
      state_nxt = HALTED;
    end else begin
      inst_nxt  = fetch_valid ? fetch_inst : NOP;
      pc_nxt    = fetch_pc_inc;
      valid_nxt = fetch_valid;
    end
  end

  // Reset overrides the combinational outputs so they settle without a clock edge.
  assign pc_hold = hold_c & ~rst;
  assign bubble  = bub_c | rst;
  assign halted  = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 2'd0;
      dec_inst   <= NOP;
      dec_pc_inc <= 16'h0000;
      dec_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dec_inst   <= inst_nxt;
      dec_pc_inc <= pc_nxt;
      dec_valid  <= valid_nxt;
    end
  end

`ifdef IFID_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if (pc_hold && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, HALT/reset sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_inst, fetch_pc_inc;
  logic        fetch_valid, stall_req, flush;
  logic [1:0]  stall_cycles;
  logic [15:0] dec_inst, dec_pc_inc;
  logic        dec_valid, pc_hold, bubble, halted;
`ifdef IFID_STATS_EN
  logic [15:0] stall_count;
`endif

  if_id_stage dut (
    .clk(clk), .rst(rst),
    .fetch_inst(fetch_inst), .fetch_pc_inc(fetch_pc_inc), .fetch_valid(fetch_valid),
    .stall_req(stall_req), .stall_cycles(stall_cycles), .flush(flush),
    .dec_inst(dec_inst), .dec_pc_inc(dec_pc_inc), .dec_valid(dec_valid),
    .pc_hold(pc_hold), .bubble(bubble), .halted(halted)
`ifdef IFID_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining forced stall cycles and a parked flag.
  logic [15:0] m_inst, m_pc;
  logic        m_valid, m_halt;
  int          m_left;
  int          m_count;

  task automatic model_reset();
    m_inst = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0;
    m_halt = 1'b0; m_left = 0; m_count = 0;
  endtask

  task automatic model_comb(output logic h, output logic b);
    if (flush)                                begin h = 1'b0; b = 1'b1; end
    else if (m_halt)                          begin h = 1'b1; b = 1'b1; end
    else if (m_left > 0)                      begin h = 1'b1; b = 1'b1; end
    else if (stall_req)                       begin h = 1'b1; b = 1'b1; end
    else if (m_valid && m_inst == 16'h0000)   begin h = 1'b1; b = 1'b0; end
    else                                      begin h = 1'b0; b = 1'b0; end
  endtask

  task automatic model_step();
    logic h, b;
    int n;
    model_comb(h, b);
    if (h && m_count < 65535) m_count++;
    if (flush) begin
      m_inst = 16'h0800; m_valid = 1'b0; m_left = 0; m_halt = 1'b0;
    end else if (m_halt) begin
    end else if (m_left > 0) begin
      m_left--;
    end else if (stall_req) begin
      n = (stall_cycles == 2'd0) ? 1 : int'(stall_cycles);
      m_left = n - 1;
    end else if (m_valid && m_inst == 16'h0000) begin
      m_halt = 1'b1;
    end else begin
      m_inst  = fetch_valid ? fetch_inst : 16'h0800;
      m_pc    = fetch_pc_inc;
      m_valid = fetch_valid;
    end
  endtask

  task automatic check_model();
    logic h, b;
    model_comb(h, b);
    chk1("m_pc_hold", pc_hold, h);
    chk1("m_bubble", bubble, b);
    chk16("m_dec_inst", dec_inst, m_inst);
    chk16("m_dec_pc_inc", dec_pc_inc, m_pc);
    chk1("m_dec_valid", dec_valid, m_valid);
    chk1("m_halted", halted, m_halt);
`ifdef IFID_STATS_EN
    chk16("m_stall_count", stall_count, 16'(m_count));
`endif
  endtask

  task automatic drive(input logic [15:0] fi, input logic [15:0] fp, input logic fv,
                       input logic sr, input logic [1:0] sc, input logic fl);
    fetch_inst = fi; fetch_pc_inc = fp; fetch_valid = fv;
    stall_req = sr; stall_cycles = sc; flush = fl;
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic cycle();
    #4 check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [15:0] fi;
    logic [15:0] fp;
    logic        fv;
    logic        sr;
    logic [1:0]  sc;
    logic        fl;
    logic        e_hold;
    logic        e_bub;
    logic [15:0] e_inst;
    logic        e_valid;
    logic        e_halt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{16'h4105, 16'h0002, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h4105, 1'b1, 1'b0};
    tbl[1]  = '{16'h1111, 16'h0004, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 16'h4105, 1'b1, 1'b0};
    tbl[2]  = '{16'h1111, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'h4105, 1'b1, 1'b0};
    tbl[3]  = '{16'h1111, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'h4105, 1'b1, 1'b0};
    tbl[4]  = '{16'h1111, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0};
    tbl[5]  = '{16'h2222, 16'h0006, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0};
    tbl[6]  = '{16'h2222, 16'h0006, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0};
    tbl[7]  = '{16'h3333, 16'h0008, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0};
    tbl[8]  = '{16'h3333, 16'h0008, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0800, 1'b0, 1'b0};
    tbl[9]  = '{16'h3333, 16'h0008, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b0};
    tbl[10] = '{16'h4444, 16'h000A, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 16'h0800, 1'b0, 1'b0};
    tbl[11] = '{16'h4444, 16'h000A, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0};
    tbl[12] = '{16'h0000, 16'h000C, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0};
    tbl[13] = '{16'h5555, 16'h000E, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0};
    tbl[14] = '{16'h0000, 16'h0010, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[15] = '{16'h6666, 16'h0012, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk16("rst_dec_inst", dec_inst, 16'h0800);
    chk1("rst_dec_valid", dec_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_pc_hold", pc_hold, 1'b0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fi, tbl[i].fp, tbl[i].fv, tbl[i].sr, tbl[i].sc, tbl[i].fl);
      #4;
      chk1($sformatf("tbl%0d_pc_hold", i), pc_hold, tbl[i].e_hold);
      chk1($sformatf("tbl%0d_bubble", i), bubble, tbl[i].e_bub);
      check_model();
      @(posedge clk);
      model_step();
      #1;
      chk16($sformatf("tbl%0d_dec_inst", i), dec_inst, tbl[i].e_inst);
      chk1($sformatf("tbl%0d_dec_valid", i), dec_valid, tbl[i].e_valid);
      chk1($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
    end
    chk16("tbl_pc_inc", dec_pc_inc, 16'h0010);

    // Parked on HALT for 20 idle cycles; stall requests must not disturb it.
    for (int i = 0; i < 20; i++) begin
      drive(16'($urandom), 16'($urandom), 1'b1, 1'(i % 2), 2'd3, 1'b0);
      #4;
      chk1("halt_pc_hold", pc_hold, 1'b1);
      chk1("halt_bubble", bubble, 1'b1);
      chk1("halt_halted", halted, 1'b1);
      chk16("halt_dec_inst", dec_inst, 16'h0000);
      @(posedge clk);
      model_step();
      #1;
    end
    drive(16'h7777, 16'h0014, 1'b1, 1'b0, 2'd0, 1'b1);
    #4;
    chk1("unhalt_pc_hold", pc_hold, 1'b0);
    chk1("unhalt_bubble", bubble, 1'b1);
    @(posedge clk);
    model_step();
    #1;
    chk1("unhalt_halted", halted, 1'b0);
    chk16("unhalt_dec_inst", dec_inst, 16'h0800);
    chk1("unhalt_dec_valid", dec_valid, 1'b0);

    // Asynchronous reset in the middle of a 3-cycle stall.
    drive(16'h7777, 16'h0014, 1'b1, 1'b1, 2'd3, 1'b0);
    cycle();
    drive(16'h7777, 16'h0014, 1'b1, 1'b0, 2'd0, 1'b0);
    #2;
    chk1("mid_stall_pc_hold", pc_hold, 1'b1);
    rst = 1'b1;
    #1;
    chk1("arst_pc_hold", pc_hold, 1'b0);
    chk16("arst_dec_inst", dec_inst, 16'h0800);
    chk1("arst_dec_valid", dec_valid, 1'b0);
`ifdef IFID_STATS_EN
    chk16("arst_stall_count", stall_count, 16'h0000);
`endif
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_step();
    #1;
    chk16("post_rst_dec_inst", dec_inst, 16'h7777);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
            16'($urandom),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
